adder_error_monitor: RTL and testbench
======================================

ADDER_ERROR_MONITOR -- requirements
Module: adder_error_monitor

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 65536, meaning the number of samples per measurement run (legal range 1..65536).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  single-cycle request to begin a run.
REQ-005 The block SHALL have port in_valid  input  1  sample pair present on approx_sum/exact_sum.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 The block SHALL have port approx_sum  input  9  unsigned approximate-adder result.
REQ-008 The block SHALL have port exact_sum  input  9  unsigned exact sum (0..510).
REQ-009 The block SHALL have port busy  output  1  run in progress.
REQ-010 The block SHALL have port done  output  1  results valid and stable.
REQ-011 The block SHALL have port sample_cnt  output  17  samples accumulated.
REQ-012 The block SHALL have port err_cnt  output  17  samples with nonzero error.
REQ-013 The block SHALL have port err_sum  output  28  signed two's-complement sum of (approx_sum - exact_sum).
REQ-014 The block SHALL have port abs_err_sum  output  26  unsigned sum of |error|.
REQ-015 The block SHALL have port sq_err_sum  output  35  unsigned sum of error squared.
REQ-016 The block SHALL have port max_abs_err  output  10  largest |error| seen in the run.

Function
REQ-017 The block SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN on start=1; all accumulators, sample_cnt, max_abs_err cleared in that same edge.
REQ-019 In RUN, in_ready SHALL be 1 while accepted-sample count < N_SAMPLES; a sample is accepted when in_valid && in_ready.
REQ-020 RUN -> DRAIN on the edge accepting sample number N_SAMPLES; in_ready=0 from the next cycle.
REQ-021 Error SHALL be computed as 11-bit signed approx_sum - exact_sum (range -510..511), |error| as 10-bit unsigned, square as 19-bit unsigned; no truncation anywhere.
REQ-022 Pipeline: stage 1 registers error, |error|, square, nonzero flag; stage 2 updates accumulators; outputs reflect a sample exactly 2 cycles after its acceptance edge.
REQ-023 in_valid gaps (in_valid=0) SHALL insert bubbles without affecting accumulators; back-to-back acceptance every cycle SHALL be supported.
REQ-024 DRAIN -> DONE once the final sample has updated stage 2 (exactly 2 cycles after RUN exit); done=1 in DONE only.
REQ-025 busy SHALL be 1 in RUN and DRAIN, else 0.
REQ-026 start SHALL be ignored in RUN and DRAIN; start in DONE SHALL behave as in IDLE (clear and enter RUN, done drops next cycle).
REQ-027 Outputs SHALL hold their values in DONE and IDLE until the next start.
REQ-028 in_ready SHALL be 0 in IDLE, DRAIN, DONE; inputs outside acceptance SHALL be ignored.
REQ-029 max_abs_err SHALL update with the larger of current and new |error|; equal values leave it unchanged.

Reset
REQ-030 rst=1 SHALL force state IDLE, flush both pipeline stages, and zero every output (in_ready, busy, done, all counts/sums/max) on the next edge.
REQ-031 rst asserted mid-run SHALL discard in-flight samples; no partial result is retained.
REQ-032 rst SHALL take priority over start on the same edge.

Verification
REQ-033 N_SAMPLES=4; samples (10,10),(12,10),(5,9),(0,0) back-to-back -> done with sample_cnt=4, err_cnt=2, err_sum=-2, abs_err_sum=6, sq_err_sum=20, max_abs_err=4.
REQ-034 N_SAMPLES=1; sample (511,0) -> err_sum=511, abs_err_sum=511, sq_err_sum=261121, max_abs_err=511; sample (0,510) separate run -> err_sum=-510 (28-bit two's complement).
REQ-035 N_SAMPLES=65536, every sample (0,510) -> abs_err_sum=33423360, sq_err_sum=17045913600, err_cnt=65536, no overflow.
REQ-036 N_SAMPLES=3 with in_valid toggling 1,0,0,1,0,1 -> only 3 samples counted; done asserts exactly 2 cycles after third acceptance; in_ready=0 afterward.
REQ-037 rst pulsed after 2 of 4 samples, then start and 4 fresh samples -> results match the fresh samples only; start pulsed during RUN -> no effect.
REQ-038 Exhaustive 256x256 run of the 8-bit approximate adder through the monitor -> all outputs equal the software-computed error metrics for the same sweep.

Source files
------------

// File: rtl/adder_error_monitor.sv
// adder_error_monitor
// Collects error statistics for an approximate adder by comparing each
// approximate result against the exact sum over a run of N_SAMPLES samples.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle request to begin a run (honoured in IDLE and DONE)
//   in_valid     a sample pair is present on approx_sum/exact_sum
//   in_ready     the block accepts a sample this cycle
//   approx_sum   9-bit unsigned approximate-adder result
//   exact_sum    9-bit unsigned exact sum
//   busy         run in progress (RUN or DRAIN)
//   done         results valid and stable
//   sample_cnt   samples accumulated
//   err_cnt      samples with nonzero error
//   err_sum      signed sum of (approx_sum - exact_sum)
//   abs_err_sum  sum of |error|
//   sq_err_sum   sum of error squared
//   max_abs_err  largest |error| seen in the run
module adder_error_monitor #(
  parameter int N_SAMPLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  approx_sum,
  input  logic [8:0]  exact_sum,
  output logic        busy,
  output logic        done,
  output logic [16:0] sample_cnt,
  output logic [16:0] err_cnt,
  output logic [27:0] err_sum,
  output logic [25:0] abs_err_sum,
  output logic [34:0] sq_err_sum,
  output logic [9:0]  max_abs_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [16:0] LAST_IDX = 17'(N_SAMPLES - 1);

  state_t      state;
  logic [16:0] acc_cnt;
  logic        drain_cnt;

  logic        accept;
  logic        start_run;
  logic [10:0] err_c;
  logic [9:0]  abs_c;
  logic [18:0] abs_w;
  logic [18:0] sq_c;

  logic        s1_valid;
  logic [10:0] s1_err;
  logic [9:0]  s1_abs;
  logic [18:0] s1_sq;
  logic        s1_nz;

  // Error arithmetic is done at full width: 11-bit signed difference covers
  // -510..511, its magnitude fits 10 bits and the square fits 19 bits.
  always_comb begin
    accept    = in_valid && in_ready;
    start_run = start && (state == IDLE || state == DONE);
    err_c     = {2'b00, approx_sum} - {2'b00, exact_sum};
    abs_c     = err_c[10] ? 10'(-err_c) : err_c[9:0];
    abs_w     = {9'b0, abs_c};
    sq_c      = abs_w * abs_w;
  end

  // Run control. in_ready is registered: it rises on entry to RUN and falls on
  // the edge that accepts the last sample. DRAIN lasts two cycles so the last
  // sample has passed through both pipeline stages before done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            acc_cnt  <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (acc_cnt == LAST_IDX) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= 1'b0;
            end else begin
              acc_cnt <= acc_cnt + 17'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: register the per-sample metrics of an accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= '0;
      s1_abs   <= '0;
      s1_sq    <= '0;
      s1_nz    <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_err   <= err_c;
      s1_abs   <= abs_c;
      s1_sq    <= sq_c;
      s1_nz    <= (err_c != 11'd0);
    end
  end

  // Stage 2: accumulators. A honoured start clears them; bubbles from
  // in_valid gaps leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      err_sum     <= '0;
      abs_err_sum <= '0;
      sq_err_sum  <= '0;
      max_abs_err <= '0;
    end else if (start_run) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      err_sum     <= '0;
      abs_err_sum <= '0;
      sq_err_sum  <= '0;
      max_abs_err <= '0;
    end else if (s1_valid) begin
      sample_cnt  <= sample_cnt + 17'd1;
      err_cnt     <= err_cnt + {16'b0, s1_nz};
      err_sum     <= err_sum + {{17{s1_err[10]}}, s1_err};
      abs_err_sum <= abs_err_sum + {16'b0, s1_abs};
      sq_err_sum  <= sq_err_sum + {16'b0, s1_sq};
      if (s1_abs > max_abs_err) begin
        max_abs_err <= s1_abs;
      end
    end
  end

endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor
// Directed bench for adder_error_monitor. Four instances with N_SAMPLES of
// 4, 1, 3 and 65536 share the sample inputs and reset; each has its own start.
module tb_adder_error_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] approx_sum = '0;
  logic [8:0] exact_sum = '0;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;

  logic        a_in_ready, a_busy, a_done;
  logic [16:0] a_sample_cnt, a_err_cnt;
  logic [27:0] a_err_sum;
  logic [25:0] a_abs_err_sum;
  logic [34:0] a_sq_err_sum;
  logic [9:0]  a_max_abs_err;

  logic        b_in_ready, b_busy, b_done;
  logic [16:0] b_sample_cnt, b_err_cnt;
  logic [27:0] b_err_sum;
  logic [25:0] b_abs_err_sum;
  logic [34:0] b_sq_err_sum;
  logic [9:0]  b_max_abs_err;

  logic        c_in_ready, c_busy, c_done;
  logic [16:0] c_sample_cnt, c_err_cnt;
  logic [27:0] c_err_sum;
  logic [25:0] c_abs_err_sum;
  logic [34:0] c_sq_err_sum;
  logic [9:0]  c_max_abs_err;

  logic        d_in_ready, d_busy, d_done;
  logic [16:0] d_sample_cnt, d_err_cnt;
  logic [27:0] d_err_sum;
  logic [25:0] d_abs_err_sum;
  logic [34:0] d_sq_err_sum;
  logic [9:0]  d_max_abs_err;

  int vectors = 0;
  int miscompares = 0;

  adder_error_monitor #(.N_SAMPLES(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(a_in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum), .busy(a_busy), .done(a_done),
    .sample_cnt(a_sample_cnt), .err_cnt(a_err_cnt), .err_sum(a_err_sum),
    .abs_err_sum(a_abs_err_sum), .sq_err_sum(a_sq_err_sum), .max_abs_err(a_max_abs_err));

  adder_error_monitor #(.N_SAMPLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(b_in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum), .busy(b_busy), .done(b_done),
    .sample_cnt(b_sample_cnt), .err_cnt(b_err_cnt), .err_sum(b_err_sum),
    .abs_err_sum(b_abs_err_sum), .sq_err_sum(b_sq_err_sum), .max_abs_err(b_max_abs_err));

  adder_error_monitor #(.N_SAMPLES(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_ready(c_in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum), .busy(c_busy), .done(c_done),
    .sample_cnt(c_sample_cnt), .err_cnt(c_err_cnt), .err_sum(c_err_sum),
    .abs_err_sum(c_abs_err_sum), .sq_err_sum(c_sq_err_sum), .max_abs_err(c_max_abs_err));

  adder_error_monitor #(.N_SAMPLES(65536)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .in_valid(in_valid), .in_ready(d_in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum), .busy(d_busy), .done(d_done),
    .sample_cnt(d_sample_cnt), .err_cnt(d_err_cnt), .err_sum(d_err_sum),
    .abs_err_sum(d_abs_err_sum), .sq_err_sum(d_sq_err_sum), .max_abs_err(d_max_abs_err));

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample pair for one clock.
  task automatic applyStimulus(input logic [8:0] ap, input logic [8:0] ex, input logic v);
    approx_sum = ap;
    exact_sum  = ex;
    in_valid   = v;
    tick();
  endtask

  // Lower-part-OR approximate 8-bit adder: low nibble ORed, high nibble added.
  function automatic logic [8:0] approx_add(input logic [7:0] x, input logic [7:0] y);
    logic [4:0] hi;
    hi = {1'b0, x[7:4]} + {1'b0, y[7:4]};
    return {hi, x[3:0] | y[3:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %0d want 0", a_in_ready); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %0d want 0", a_busy); end
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %0d want 0", a_done); end
    vectors++; if (a_sample_cnt !== 17'd0) begin miscompares++; $display("[TB] FAIL reset_sample_cnt got %0d want 0", a_sample_cnt); end
    vectors++; if (a_err_sum !== 28'd0) begin miscompares++; $display("[TB] FAIL reset_err_sum got %0h want 0", a_err_sum); end
    vectors++; if (a_sq_err_sum !== 35'd0) begin miscompares++; $display("[TB] FAIL reset_sq_err_sum got %0d want 0", a_sq_err_sum); end
    vectors++; if (a_max_abs_err !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_max got %0d want 0", a_max_abs_err); end
    vectors++; if (d_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_d got %0d want 0", d_busy); end
  endtask

  task automatic test_back_to_back();
    int k;
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_in_ready got %0d want 0", a_in_ready); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL run_busy got %0d want 1", a_busy); end
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL run_in_ready got %0d want 1", a_in_ready); end
    applyStimulus(9'd10, 9'd10, 1'b1);
    applyStimulus(9'd12, 9'd10, 1'b1);
    applyStimulus(9'd5,  9'd9,  1'b1);
    applyStimulus(9'd0,  9'd0,  1'b1);
    in_valid = 1'b0;
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_in_ready got %0d want 0", a_in_ready); end
    vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_busy got %0d want 1", a_busy); end
    k = 0;
    while (a_done !== 1'b1 && k < 10) begin tick(); k++; end
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done_timeout got %0d want 1", a_done); end
    vectors++; if (k !== 2) begin miscompares++; $display("[TB] FAIL b2b_done_latency got %0d want 2", k); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL done_busy got %0d want 0", a_busy); end
    vectors++; if (a_sample_cnt !== 17'd4) begin miscompares++; $display("[TB] FAIL b2b_sample_cnt got %0d want 4", a_sample_cnt); end
    vectors++; if (a_err_cnt !== 17'd2) begin miscompares++; $display("[TB] FAIL b2b_err_cnt got %0d want 2", a_err_cnt); end
    vectors++; if (a_err_sum !== 28'hFFFFFFE) begin miscompares++; $display("[TB] FAIL b2b_err_sum got %0h want ffffffe", a_err_sum); end
    vectors++; if (a_abs_err_sum !== 26'd6) begin miscompares++; $display("[TB] FAIL b2b_abs_err_sum got %0d want 6", a_abs_err_sum); end
    vectors++; if (a_sq_err_sum !== 35'd20) begin miscompares++; $display("[TB] FAIL b2b_sq_err_sum got %0d want 20", a_sq_err_sum); end
    vectors++; if (a_max_abs_err !== 10'd4) begin miscompares++; $display("[TB] FAIL b2b_max got %0d want 4", a_max_abs_err); end
  endtask

  task automatic test_hold_and_restart();
    applyStimulus(9'd300, 9'd0, 1'b1);
    applyStimulus(9'd300, 9'd0, 1'b1);
    applyStimulus(9'd300, 9'd0, 1'b1);
    in_valid = 1'b0;
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_done got %0d want 1", a_done); end
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_in_ready got %0d want 0", a_in_ready); end
    vectors++; if (a_sample_cnt !== 17'd4) begin miscompares++; $display("[TB] FAIL hold_sample_cnt got %0d want 4", a_sample_cnt); end
    vectors++; if (a_err_sum !== 28'hFFFFFFE) begin miscompares++; $display("[TB] FAIL hold_err_sum got %0h want ffffffe", a_err_sum); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_done got %0d want 0", a_done); end
    vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_busy got %0d want 1", a_busy); end
    vectors++; if (a_sample_cnt !== 17'd0) begin miscompares++; $display("[TB] FAIL restart_sample_cnt got %0d want 0", a_sample_cnt); end
    vectors++; if (a_err_sum !== 28'd0) begin miscompares++; $display("[TB] FAIL restart_err_sum got %0h want 0", a_err_sum); end
    vectors++; if (a_max_abs_err !== 10'd0) begin miscompares++; $display("[TB] FAIL restart_max got %0d want 0", a_max_abs_err); end
  endtask

  task automatic test_reset_midrun();
    int k;
    applyStimulus(9'd200, 9'd0, 1'b1);
    applyStimulus(9'd0, 9'd200, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    rst = 1'b0;
    start_a = 1'b0;
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_over_start_busy got %0d want 0", a_busy); end
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready got %0d want 0", a_in_ready); end
    tick();
    tick();
    vectors++; if (a_sample_cnt !== 17'd0) begin miscompares++; $display("[TB] FAIL rst_flush_sample_cnt got %0d want 0", a_sample_cnt); end
    vectors++; if (a_abs_err_sum !== 26'd0) begin miscompares++; $display("[TB] FAIL rst_flush_abs got %0d want 0", a_abs_err_sum); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_idle_busy got %0d want 0", a_busy); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    applyStimulus(9'd1, 9'd2, 1'b1);
    applyStimulus(9'd3, 9'd3, 1'b1);
    start_a = 1'b1;
    applyStimulus(9'd9, 9'd4, 1'b1);
    start_a = 1'b0;
    applyStimulus(9'd4, 9'd4, 1'b1);
    in_valid = 1'b0;
    k = 0;
    while (a_done !== 1'b1 && k < 10) begin tick(); k++; end
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("[TB] FAIL fresh_done_timeout got %0d want 1", a_done); end
    vectors++; if (a_sample_cnt !== 17'd4) begin miscompares++; $display("[TB] FAIL fresh_sample_cnt got %0d want 4", a_sample_cnt); end
    vectors++; if (a_err_cnt !== 17'd2) begin miscompares++; $display("[TB] FAIL fresh_err_cnt got %0d want 2", a_err_cnt); end
    vectors++; if (a_err_sum !== 28'd4) begin miscompares++; $display("[TB] FAIL fresh_err_sum got %0h want 4", a_err_sum); end
    vectors++; if (a_abs_err_sum !== 26'd6) begin miscompares++; $display("[TB] FAIL fresh_abs got %0d want 6", a_abs_err_sum); end
    vectors++; if (a_sq_err_sum !== 35'd26) begin miscompares++; $display("[TB] FAIL fresh_sq got %0d want 26", a_sq_err_sum); end
    vectors++; if (a_max_abs_err !== 10'd5) begin miscompares++; $display("[TB] FAIL fresh_max got %0d want 5", a_max_abs_err); end
  endtask

  task automatic test_single_extremes();
    int k;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    applyStimulus(9'd511, 9'd0, 1'b1);
    in_valid = 1'b0;
    vectors++; if (b_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL n1_in_ready got %0d want 0", b_in_ready); end
    k = 0;
    while (b_done !== 1'b1 && k < 10) begin tick(); k++; end
    vectors++; if (b_done !== 1'b1) begin miscompares++; $display("[TB] FAIL n1_done_timeout got %0d want 1", b_done); end
    vectors++; if (b_sample_cnt !== 17'd1) begin miscompares++; $display("[TB] FAIL n1_sample_cnt got %0d want 1", b_sample_cnt); end
    vectors++; if (b_err_sum !== 28'd511) begin miscompares++; $display("[TB] FAIL pos_err_sum got %0d want 511", b_err_sum); end
    vectors++; if (b_abs_err_sum !== 26'd511) begin miscompares++; $display("[TB] FAIL pos_abs got %0d want 511", b_abs_err_sum); end
    vectors++; if (b_sq_err_sum !== 35'd261121) begin miscompares++; $display("[TB] FAIL pos_sq got %0d want 261121", b_sq_err_sum); end
    vectors++; if (b_max_abs_err !== 10'd511) begin miscompares++; $display("[TB] FAIL pos_max got %0d want 511", b_max_abs_err); end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    applyStimulus(9'd0, 9'd510, 1'b1);
    in_valid = 1'b0;
    k = 0;
    while (b_done !== 1'b1 && k < 10) begin tick(); k++; end
    vectors++; if (b_done !== 1'b1) begin miscompares++; $display("[TB] FAIL neg_done_timeout got %0d want 1", b_done); end
    vectors++; if (b_err_sum !== 28'hFFFFE02) begin miscompares++; $display("[TB] FAIL neg_err_sum got %0h want ffffe02", b_err_sum); end
    vectors++; if (b_abs_err_sum !== 26'd510) begin miscompares++; $display("[TB] FAIL neg_abs got %0d want 510", b_abs_err_sum); end
    vectors++; if (b_sq_err_sum !== 35'd260100) begin miscompares++; $display("[TB] FAIL neg_sq got %0d want 260100", b_sq_err_sum); end
    vectors++; if (b_max_abs_err !== 10'd510) begin miscompares++; $display("[TB] FAIL neg_max got %0d want 510", b_max_abs_err); end
    vectors++; if (b_err_cnt !== 17'd1) begin miscompares++; $display("[TB] FAIL neg_err_cnt got %0d want 1", b_err_cnt); end
  endtask

  task automatic test_gaps();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    applyStimulus(9'd7,   9'd3,   1'b1);
    applyStimulus(9'd255, 9'd0,   1'b0);
    applyStimulus(9'd255, 9'd0,   1'b0);
    vectors++; if (c_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_in_ready got %0d want 1", c_in_ready); end
    applyStimulus(9'd2,   9'd9,   1'b1);
    applyStimulus(9'd255, 9'd0,   1'b0);
    applyStimulus(9'd100, 9'd100, 1'b1);
    vectors++; if (c_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_last_in_ready got %0d want 0", c_in_ready); end
    applyStimulus(9'd50, 9'd0, 1'b1);
    vectors++; if (c_done !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_done_early got %0d want 0", c_done); end
    applyStimulus(9'd50, 9'd0, 1'b1);
    in_valid = 1'b0;
    vectors++; if (c_done !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_done_at_2 got %0d want 1", c_done); end
    vectors++; if (c_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_done_in_ready got %0d want 0", c_in_ready); end
    vectors++; if (c_sample_cnt !== 17'd3) begin miscompares++; $display("[TB] FAIL gap_sample_cnt got %0d want 3", c_sample_cnt); end
    vectors++; if (c_err_cnt !== 17'd2) begin miscompares++; $display("[TB] FAIL gap_err_cnt got %0d want 2", c_err_cnt); end
    vectors++; if (c_err_sum !== 28'hFFFFFFD) begin miscompares++; $display("[TB] FAIL gap_err_sum got %0h want ffffffd", c_err_sum); end
    vectors++; if (c_abs_err_sum !== 26'd11) begin miscompares++; $display("[TB] FAIL gap_abs got %0d want 11", c_abs_err_sum); end
    vectors++; if (c_sq_err_sum !== 35'd65) begin miscompares++; $display("[TB] FAIL gap_sq got %0d want 65", c_sq_err_sum); end
    vectors++; if (c_max_abs_err !== 10'd7) begin miscompares++; $display("[TB] FAIL gap_max got %0d want 7", c_max_abs_err); end
  endtask

  task automatic test_exhaustive();
    longint m_sum, m_abs, m_sq, m_cnt, m_nz, m_max, e, ae;
    logic [8:0] ap, ex;
    int k;
    m_sum = 0; m_abs = 0; m_sq = 0; m_cnt = 0; m_nz = 0; m_max = 0;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        ap = approx_add(8'(i), 8'(j));
        ex = 9'(i + j);
        e  = longint'(ap) - longint'(ex);
        ae = (e < 0) ? -e : e;
        m_sum += e;
        m_abs += ae;
        m_sq  += e * e;
        m_cnt++;
        if (e != 0) m_nz++;
        if (ae > m_max) m_max = ae;
        applyStimulus(ap, ex, 1'b1);
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (d_done !== 1'b1 && k < 20) begin tick(); k++; end
    vectors++; if (d_done !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_done_timeout got %0d want 1", d_done); end
    vectors++; if (d_sample_cnt !== 17'(m_cnt)) begin miscompares++; $display("[TB] FAIL sweep_sample_cnt got %0d want %0d", d_sample_cnt, m_cnt); end
    vectors++; if (d_err_cnt !== 17'(m_nz)) begin miscompares++; $display("[TB] FAIL sweep_err_cnt got %0d want %0d", d_err_cnt, m_nz); end
    vectors++; if (d_err_sum !== 28'(m_sum)) begin miscompares++; $display("[TB] FAIL sweep_err_sum got %0h want %0h", d_err_sum, 28'(m_sum)); end
    vectors++; if (d_abs_err_sum !== 26'(m_abs)) begin miscompares++; $display("[TB] FAIL sweep_abs got %0d want %0d", d_abs_err_sum, m_abs); end
    vectors++; if (d_sq_err_sum !== 35'(m_sq)) begin miscompares++; $display("[TB] FAIL sweep_sq got %0d want %0d", d_sq_err_sum, m_sq); end
    vectors++; if (d_max_abs_err !== 10'(m_max)) begin miscompares++; $display("[TB] FAIL sweep_max got %0d want %0d", d_max_abs_err, m_max); end
  endtask

  initial begin
    $display("[TB] adder_error_monitor directed tests");
    test_reset();
    test_back_to_back();
    test_hold_and_restart();
    test_reset_midrun();
    test_single_extremes();
    test_gaps();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
